// File: rtl/mem_stage.sv
// MEM pipeline stage: registers the EX->MEM bus, captures and holds the SRAM read word, and drives WB and forwarding.
// Optional sub-word load extraction is enabled by defining MEM_SUBWORD_LOAD_EN.
module mem_stage #(
  parameter int EX_TO_MEM_WD = 76,
  parameter int MEM_TO_WB_WD = 70,
  parameter int StallBus     = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [StallBus-1:0]     stall,
  input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  input  logic [2:0]              ex_load_op,
  input  logic [31:0]             data_sram_rdata,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic [37:0]             mem_to_rf_bus
);

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  typedef enum logic [2:0] {
    LD_NONE = 3'd0,
    LD_B    = 3'd1,
    LD_BU   = 3'd2,
    LD_H    = 3'd3,
    LD_HU   = 3'd4,
    LD_W    = 3'd5
  } load_op_e;

  logic [EX_TO_MEM_WD-1:0] bus_r;
  logic                    first;
  logic [31:0]             rdata_hold;
  logic [31:0]             rdata_sel;
  logic [31:0]             load_data;

  logic                    load_en;
  logic                    bubble;

  assign load_en = (stall[3] == NoStop);
  assign bubble  = (stall[3] == Stop) && (stall[4] == NoStop);

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_r <= '0;
    end else if (bubble) begin
      bus_r <= '0;
    end else if (load_en) begin
      bus_r <= ex_to_mem_bus;
    end
  end

  // The word sampled in the first MEM cycle stays in use for the whole residency.
  always_ff @(posedge clk) begin
    if (rst) begin
      first      <= 1'b0;
      rdata_hold <= '0;
    end else begin
      first      <= load_en;
      rdata_hold <= rdata_sel;
    end
  end

  assign rdata_sel = first ? data_sram_rdata : rdata_hold;

  logic [31:0] pc;
  logic        sel_rf_res;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] ex_result;
  logic [31:0] rf_wdata;

  assign pc         = bus_r[75:44];
  assign sel_rf_res = bus_r[38];
  assign rf_we      = bus_r[37];
  assign rf_waddr   = bus_r[36:32];
  assign ex_result  = bus_r[31:0];

`ifdef MEM_SUBWORD_LOAD_EN
  logic [2:0]  op_r;
  logic [1:0]  off;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_ff @(posedge clk) begin
    if (rst) begin
      op_r <= '0;
    end else if (bubble) begin
      op_r <= '0;
    end else if (load_en) begin
      op_r <= ex_load_op;
    end
  end

  assign off    = ex_result[1:0];
  assign byte_v = rdata_sel[{off, 3'b000} +: 8];
  assign half_v = rdata_sel[{off[1], 4'b0000} +: 16];

  always_comb begin
    load_data = rdata_sel;
    case (op_r)
      LD_B:    load_data = {{24{byte_v[7]}}, byte_v};
      LD_BU:   load_data = {24'h000000, byte_v};
      LD_H:    load_data = {{16{half_v[15]}}, half_v};
      LD_HU:   load_data = {16'h0000, half_v};
      default: load_data = rdata_sel;
    endcase
  end

  logic unused_bits;
  assign unused_bits = ^{bus_r[43:39], stall[5], stall[2:0], LD_NONE, LD_W};
`else
  assign load_data = rdata_sel;

  logic unused_bits;
  assign unused_bits = ^{bus_r[43:39], stall[5], stall[2:0], ex_load_op};
`endif

  assign rf_wdata      = sel_rf_res ? load_data : ex_result;
  assign mem_to_wb_bus = {pc, rf_we, rf_waddr, rf_wdata};
  assign mem_to_rf_bus = {rf_we, rf_waddr, rf_wdata};

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage sitting directly downstream of EX and upstream of WB. Registers the EX→MEM bus under the common stall protocol. Captures the synchronous data-SRAM read word and holds it across MEM stalls. Extracts and extends load data, then drives the MEM→WB bus and the MEM forwarding bus back to ID.

## Interface
- `EX_TO_MEM_WD`, 76: width of the incoming bus, `{pc[75:44], data_ram_en[43], data_ram_wen[42:39], sel_rf_res[38], rf_we[37], rf_waddr[36:32], ex_result[31:0]}`.
- `MEM_TO_WB_WD`, 70: width of the outgoing bus, `{pc[69:38], rf_we[37], rf_waddr[36:32], rf_wdata[31:0]}`.
- `StallBus`, 6: stall vector width. `Stop`=1, `NoStop`=0.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `stall` in `StallBus`: global stall vector. Bit 3 is EX, bit 4 is MEM.
- `ex_to_mem_bus` in `EX_TO_MEM_WD`: EX stage outputs.
- `ex_load_op` in 3: load type from EX. Encodings: 000 none, 001 LB, 010 LBU, 011 LH, 100 LHU, 101 LW, others treated as LW.
- `data_sram_rdata` in 32: data-SRAM read word, valid the cycle after EX issued the address.
- `mem_to_wb_bus` out `MEM_TO_WB_WD`: registered instruction with final write data.
- `mem_to_rf_bus` out 38: `{rf_we, rf_waddr, rf_wdata}` forwarding path to ID.

## Operation
**Pipeline register** `{ex_to_mem_bus, ex_load_op}`, updated on each clock edge by the first matching rule:
  - `rst`: cleared to 0.
  - `stall[3]==Stop && stall[4]==NoStop`: cleared to 0 (bubble).
  - `stall[3]==NoStop`: loaded from the inputs.
  - Otherwise: holds.

**Read-data capture**
- `first` flag: set to 1 on a load edge (`stall[3]==NoStop`, no reset); set to 0 on any other edge; 0 on reset.
- `rdata_sel = first ? data_sram_rdata : rdata_hold`.
- `rdata_hold <= rdata_sel` every cycle; 0 on reset.
- Result: the SRAM word seen in the instruction's first MEM cycle is used for its entire MEM residency, even if the SRAM output changes during a stall.

**Load extraction**
- `off` = registered `ex_result[1:0]`.
- LB / LBU: byte `rdata_sel[8*off+7 : 8*off]`, sign-extended (LB) or zero-extended (LBU) to 32 bits.
- LH / LHU: halfword `rdata_sel[16*off[1]+15 : 16*off[1]]`, sign-extended or zero-extended. `off[0]` is ignored; no misalignment exception.
- LW, op 000, undefined op: `rdata_sel` unchanged; `off` ignored.

**Result selection**
- `rf_wdata = sel_rf_res ? load_data : ex_result`.
- Both output buses are combinational from the registered state and `rdata_sel`.

## Timing
- Latency: an instruction accepted on edge N appears on the outputs during cycle N+1.
- Reset: every output field is 0, including `rf_we`=0, so no writeback and no forwarding.
- Bubble: all fields 0, so `rf_we`=0 and `pc`=0.
- Held stage (`stall[3]==Stop` and `stall[4]==Stop`): outputs stay constant cycle to cycle, including load data.
- Reset asserted mid-stall: the pipeline register, `first` and `rdata_hold` all clear on that edge.
- Store (`data_ram_wen` nonzero): passes through with `rf_we` as supplied by EX. This block does not touch the SRAM.

## Configuration
- `MEM_SUBWORD_LOAD_EN` defined: LB, LBU, LH, LHU extraction is compiled in as above.
- Undefined: `ex_load_op` is not registered, extraction logic is absent, and `load_data = rdata_sel` for every load. Capture and hold behaviour is unchanged.

## Test plan
- Reset: assert `rst` for 2 cycles with a random bus → `mem_to_wb_bus`==0 and `mem_to_rf_bus`==0.
- LW: `ex_result`=0x100, `sel_rf_res`=1, `rf_we`=1, `waddr`=5; next cycle `data_sram_rdata`=0xDEADBEEF → `mem_to_rf_bus`={1,5,0xDEADBEEF}.
- LB and LHU (macro on): rdata=0x80FF7F01.
  - LB at `off`=3 → 0xFFFFFF80.
  - LBU at `off`=0 → 0x00000001.
  - LHU at `off`=2 → 0x000080FF.
  - LH at `off`=1 → 0x00007F01.
- Stall hold: LW enters with rdata=0x12345678; then `stall[4:3]`=11 for 3 cycles while rdata changes to 0xAAAAAAAA → `rf_wdata` stays 0x12345678 in every cycle.
- Bubble: `stall[4:3]`=01 at an edge → next cycle `rf_we`=0 and `pc`=0. Release → the following instruction is loaded.
- Macro off: LB op with rdata=0x80FF7F01 at `off`=3 → `rf_wdata`=0x80FF7F01.
